// File: rtl/host_mem_pkg.sv
// Shared encodings for the host memory arbiter: host op codes, FSM states, beat sizing.
package host_mem_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_GAP
  } arb_state_t;

  // Byte distance between consecutive beats of a burst.
  function automatic int beat_bytes(input int bus_w);
    return bus_w / 8;
  endfunction

endpackage

// File: rtl/host_mem_arbiter_if.sv
// Requester-side and host-side signals of the arbiter; master = arbiter, slave = requesters + host.
interface host_mem_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int BUS_W  = 512,
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 8
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*BEAT_W-1:0] req_beats;
  logic [NUM_CH*BUS_W-1:0]  ch_wr_data;
  logic [NUM_CH-1:0]        ch_grant;
  logic [NUM_CH-1:0]        ch_beat_ack;
  logic [BUS_W-1:0]         ch_rd_data;
  logic [NUM_CH-1:0]        ch_done;
  logic                     err;
  logic [1:0]               op;
  logic [ADDR_W-1:0]        io_addr;
  logic [BUS_W-1:0]         common_data_bus_out;
  logic [BUS_W-1:0]         common_data_bus_in;
  logic                     tx_done;
  logic                     rd_valid;

  modport master (
    input  req_valid, req_write, req_addr, req_beats, ch_wr_data,
    input  common_data_bus_in, tx_done, rd_valid,
    output ch_grant, ch_beat_ack, ch_rd_data, ch_done, err,
    output op, io_addr, common_data_bus_out
  );

  modport slave (
    output req_valid, req_write, req_addr, req_beats, ch_wr_data,
    output common_data_bus_in, tx_done, rd_valid,
    input  ch_grant, ch_beat_ack, ch_rd_data, ch_done, err,
    input  op, io_addr, common_data_bus_out
  );
endinterface

// File: rtl/host_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after i_ptr wins; o_nxt_ptr = winner+1.
module rr_arbiter #(
  parameter  int NUM_CH = 3,
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [PTR_W-1:0]  o_nxt_ptr
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_gnt     = '0;
    o_nxt_ptr = i_ptr;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % NUM_CH);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_gnt[w_idx]   = 1'b1;
        o_nxt_ptr      = (int'(w_idx) == NUM_CH - 1) ? '0 : w_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/host_mem_arbiter.sv
// Round-robin arbiter of NUM_CH burst requesters onto one host bus; grant and op one cycle after a request in IDLE.
// Host stalls via tx_done/rd_valid, bounded by a per-state watchdog; no preemption once a burst starts.
module host_mem_arbiter
  import host_mem_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int BUS_W       = 512,
  parameter int ADDR_W      = 32,
  parameter int BEAT_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  host_mem_arbiter_if.master bus
);

  localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                WD_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit                WD_EN    = (TIMEOUT_CYC > 0);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_EN ? WD_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(beat_bytes(BUS_W));

  arb_state_t        r_state, w_nxt_state;
  logic [CH_W-1:0]   r_ch, w_nxt_ch, r_ptr, w_nxt_ptr;
  logic [ADDR_W-1:0] r_addr, w_nxt_addr, r_io_addr, w_nxt_io_addr;
  logic [BEAT_W-1:0] r_beats, w_nxt_beats;
  logic [WD_W-1:0]   r_wd, w_nxt_wd;
  logic [1:0]        r_op, w_nxt_op;
  logic [BUS_W-1:0]  r_bus_out, w_nxt_bus_out, r_rd_data, w_nxt_rd_data;
  logic [NUM_CH-1:0] r_grant, w_nxt_grant, r_ack, w_nxt_ack, r_done, w_nxt_done;
  logic              r_err, w_nxt_err;

  logic [NUM_CH-1:0] w_gnt, w_ch_oh;
  logic [CH_W-1:0]   w_rr_nxt, w_win, w_lane_ch;
  logic [ADDR_W-1:0] w_req_addr, w_addr_inc;
  logic [BEAT_W-1:0] w_req_beats;
  logic [BUS_W-1:0]  w_lane;
  logic              w_last, w_tmo;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_nxt_ptr (w_rr_nxt)
  );

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt[i]) w_win = CH_W'(i);
    end
  end

  // Write lane is sampled on entry to WR_REQ: from the winner out of IDLE, else the owner.
  assign w_lane_ch   = (r_state == ST_IDLE) ? w_win : r_ch;
  assign w_lane      = bus.ch_wr_data[w_lane_ch*BUS_W +: BUS_W];
  assign w_req_addr  = bus.req_addr[w_win*ADDR_W +: ADDR_W];
  assign w_req_beats = bus.req_beats[w_win*BEAT_W +: BEAT_W];
  assign w_ch_oh     = NUM_CH'(1) << r_ch;
  assign w_addr_inc  = r_addr + ADDR_INC;
  assign w_last      = (r_beats == BEAT_W'(1));
  assign w_tmo       = WD_EN && (r_wd == WD_LAST);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_ch      = r_ch;
    w_nxt_ptr     = r_ptr;
    w_nxt_addr    = r_addr;
    w_nxt_beats   = r_beats;
    w_nxt_op      = r_op;
    w_nxt_io_addr = r_io_addr;
    w_nxt_bus_out = r_bus_out;
    w_nxt_rd_data = r_rd_data;
    w_nxt_grant   = '0;
    w_nxt_ack     = '0;
    w_nxt_done    = '0;
    w_nxt_err     = 1'b0;
    w_nxt_wd      = '0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          w_nxt_ch      = w_win;
          w_nxt_ptr     = w_rr_nxt;
          w_nxt_addr    = w_req_addr;
          w_nxt_io_addr = w_req_addr;
          w_nxt_beats   = (w_req_beats == '0) ? BEAT_W'(1) : w_req_beats;
          w_nxt_grant   = w_gnt;
          if (bus.req_write[w_win]) begin
            w_nxt_state   = ST_WR_REQ;
            w_nxt_op      = OP_WR;
            w_nxt_bus_out = w_lane;
          end else begin
            w_nxt_state = ST_RD_REQ;
            w_nxt_op    = OP_RD;
          end
        end
      end
      ST_RD_REQ: begin
        if (bus.tx_done) begin
          w_nxt_state = ST_RD_DATA;
          w_nxt_op    = OP_IDLE;
        end else if (w_tmo) begin
          w_nxt_state = ST_IDLE;
          w_nxt_op    = OP_IDLE;
          w_nxt_done  = w_ch_oh;
          w_nxt_err   = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (bus.rd_valid) begin
          w_nxt_rd_data = bus.common_data_bus_in;
          w_nxt_ack     = w_ch_oh;
          if (w_last) begin
            w_nxt_state = ST_IDLE;
            w_nxt_done  = w_ch_oh;
          end else begin
            w_nxt_state   = ST_RD_REQ;
            w_nxt_op      = OP_RD;
            w_nxt_beats   = r_beats - 1'b1;
            w_nxt_addr    = w_addr_inc;
            w_nxt_io_addr = w_addr_inc;
          end
        end else if (w_tmo) begin
          w_nxt_state = ST_IDLE;
          w_nxt_done  = w_ch_oh;
          w_nxt_err   = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (bus.tx_done) begin
          w_nxt_ack = w_ch_oh;
          w_nxt_op  = OP_IDLE;
          if (w_last) begin
            w_nxt_state = ST_IDLE;
            w_nxt_done  = w_ch_oh;
          end else begin
            w_nxt_state = ST_WR_GAP;
            w_nxt_beats = r_beats - 1'b1;
          end
        end else if (w_tmo) begin
          w_nxt_state = ST_IDLE;
          w_nxt_op    = OP_IDLE;
          w_nxt_done  = w_ch_oh;
          w_nxt_err   = 1'b1;
        end
      end
      ST_WR_GAP: begin
        w_nxt_state   = ST_WR_REQ;
        w_nxt_op      = OP_WR;
        w_nxt_addr    = w_addr_inc;
        w_nxt_io_addr = w_addr_inc;
        w_nxt_bus_out = w_lane;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    // Watchdog measures time spent in the current wait state only.
    if (WD_EN && (w_nxt_state == r_state) &&
        (r_state == ST_RD_REQ || r_state == ST_RD_DATA || r_state == ST_WR_REQ)) begin
      w_nxt_wd = r_wd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_ptr     <= '0;
      r_addr    <= '0;
      r_beats   <= '0;
      r_wd      <= '0;
      r_op      <= OP_IDLE;
      r_io_addr <= '0;
      r_bus_out <= '0;
      r_rd_data <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_ch      <= w_nxt_ch;
      r_ptr     <= w_nxt_ptr;
      r_addr    <= w_nxt_addr;
      r_beats   <= w_nxt_beats;
      r_wd      <= w_nxt_wd;
      r_op      <= w_nxt_op;
      r_io_addr <= w_nxt_io_addr;
      r_bus_out <= w_nxt_bus_out;
      r_rd_data <= w_nxt_rd_data;
      r_grant   <= w_nxt_grant;
      r_ack     <= w_nxt_ack;
      r_done    <= w_nxt_done;
      r_err     <= w_nxt_err;
    end
  end

  assign bus.op                  = r_op;
  assign bus.io_addr             = r_io_addr;
  assign bus.common_data_bus_out = r_bus_out;
  assign bus.ch_rd_data          = r_rd_data;
  assign bus.ch_grant            = r_grant;
  assign bus.ch_beat_ack         = r_ack;
  assign bus.ch_done             = r_done;
  assign bus.err                 = r_err;

endmodule

// File: tb/tb_host_mem_arbiter.sv
// Randomized bench: requester/host behaviour driven from tasks, expectations from a round-robin and burst model.
module tb_host_mem_arbiter;

  localparam int NUM_CH = 3;
  localparam int BUS_W  = 512;
  localparam int ADDR_W = 32;
  localparam int BEAT_W = 8;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   rr_ptr = 0;

  int               t_wr    [NUM_CH];
  int               t_beats [NUM_CH];
  int               t_delay [NUM_CH];
  int               t_tmo   [NUM_CH];
  int               t_rst   [NUM_CH];
  logic [31:0]      t_addr  [NUM_CH];
  logic [BUS_W-1:0] cur_lane[NUM_CH];

  host_mem_arbiter_if #(.NUM_CH(NUM_CH), .BUS_W(BUS_W), .ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) bif ();

  host_mem_arbiter #(
    .NUM_CH(NUM_CH), .BUS_W(BUS_W), .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BUS_W-1:0] rand_bus();
    logic [BUS_W-1:0] r;
    for (int i = 0; i < BUS_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] oh(input int c);
    return NUM_CH'(1) << c;
  endfunction

  function automatic int pick(input logic [NUM_CH-1:0] pend);
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend[(rr_ptr + i) % NUM_CH]) return (rr_ptr + i) % NUM_CH;
    end
    return 0;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_op"},    bif.op, 0);
    chk({tag, "_addr"},  bif.io_addr, 0);
    chk({tag, "_wdat"},  bif.common_data_bus_out, 0);
    chk({tag, "_rdat"},  bif.ch_rd_data, 0);
    chk({tag, "_grant"}, bif.ch_grant, 0);
    chk({tag, "_ack"},   bif.ch_beat_ack, 0);
    chk({tag, "_done"},  bif.ch_done, 0);
    chk({tag, "_err"},   bif.err, 0);
  endtask

  task automatic set_req(input int ch, input int wr, input logic [31:0] addr, input int beats);
    t_wr[ch] = wr; t_addr[ch] = addr; t_beats[ch] = beats;
    t_delay[ch] = -1; t_tmo[ch] = 0; t_rst[ch] = -1;
    bif.req_write[ch] = (wr != 0);
    bif.req_addr[ch*ADDR_W +: ADDR_W] = addr;
    bif.req_beats[ch*BEAT_W +: BEAT_W] = BEAT_W'(beats);
    cur_lane[ch] = rand_bus();
    bif.ch_wr_data[ch*BUS_W +: BUS_W] = cur_lane[ch];
  endtask

  // Wait states: host stays busy, optionally toggling signals the current state must ignore.
  task automatic wait_cycles(input int n, input bit stray_tx, input bit stray_rd, input logic [1:0] exp_op);
    for (int i = 0; i < n; i++) begin
      bif.tx_done  = stray_tx && ($urandom_range(0, 1) == 1);
      bif.rd_valid = stray_rd && ($urandom_range(0, 1) == 1);
      bif.common_data_bus_in = rand_bus();
      step();
      chk("wait_ack", bif.ch_beat_ack, 0);
      chk("wait_done", bif.ch_done, 0);
      chk("wait_op", bif.op, exp_op);
    end
    bif.tx_done  = 1'b0;
    bif.rd_valid = 1'b0;
  endtask

  task automatic serve_burst(input int ch);
    logic [31:0]      a;
    logic [BUS_W-1:0] rdat;
    logic [1:0]       bop;
    int               n, d;
    bit               wr, last;
    a   = t_addr[ch];
    wr  = (t_wr[ch] != 0);
    n   = (t_beats[ch] == 0) ? 1 : t_beats[ch];
    bop = wr ? 2'b11 : 2'b01;
    for (int k = 0; k < n; k++) begin
      chk("beat_op", bif.op, bop);
      chk("beat_addr", bif.io_addr, a);
      if (wr) chk("wr_data", bif.common_data_bus_out, cur_lane[ch]);
      if (t_tmo[ch] != 0) begin
        for (int c = 1; c < TMO; c++) begin
          step();
          chk("tmo_wait", {bif.err, bif.ch_done}, 0);
        end
        step();
        chk("tmo_err", bif.err, 1);
        chk("tmo_done", bif.ch_done, oh(ch));
        chk("tmo_op", bif.op, 0);
        step();
        chk("tmo_err_pulse", bif.err, 0);
        return;
      end
      if (k == t_rst[ch]) begin
        rst = 1'b1;
        step();
        chk_reset("rst_mid");
        rr_ptr = 0;
        rst = 1'b0;
        step();
        chk("post_rst_done", bif.ch_done, 0);
        chk("post_rst_op", bif.op, 0);
        return;
      end
      d = (k == 0 && t_delay[ch] >= 0) ? t_delay[ch] : $urandom_range(0, 4);
      wait_cycles(d, 1'b0, 1'b1, bop);
      bif.tx_done = 1'b1;
      if (!wr && $urandom_range(0, 1) == 1) begin
        bif.rd_valid = 1'b1;
        bif.common_data_bus_in = rand_bus();
      end
      step();
      bif.tx_done  = 1'b0;
      bif.rd_valid = 1'b0;
      if (!wr) begin
        chk("rd_req_noack", bif.ch_beat_ack, 0);
        chk("rd_data_op", bif.op, 0);
        wait_cycles($urandom_range(0, 3), 1'b1, 1'b0, 2'b00);
        rdat = rand_bus();
        bif.common_data_bus_in = rdat;
        bif.rd_valid = 1'b1;
        step();
        bif.rd_valid = 1'b0;
        chk("rd_ack", bif.ch_beat_ack, oh(ch));
        chk("rd_data", bif.ch_rd_data, rdat);
      end else begin
        chk("wr_ack", bif.ch_beat_ack, oh(ch));
      end
      last = (k == n - 1);
      chk("done", bif.ch_done, last ? oh(ch) : '0);
      chk("err", bif.err, 0);
      a = a + 32'd64;
      if (last) chk("end_op", bif.op, 0);
      if (wr && !last) begin
        chk("gap_op", bif.op, 0);
        cur_lane[ch] = rand_bus();
        bif.ch_wr_data[ch*BUS_W +: BUS_W] = cur_lane[ch];
        step();
      end
    end
  endtask

  task automatic run_round(input logic [NUM_CH-1:0] mask);
    logic [NUM_CH-1:0] pend;
    int exp_ch, lat;
    bif.req_valid = mask;
    pend = mask;
    while (pend != '0) begin
      exp_ch = pick(pend);
      lat = 0;
      do begin
        step();
        lat++;
      end while (bif.ch_grant == '0 && lat < 20);
      chk("grant", bif.ch_grant, oh(exp_ch));
      chk("grant_lat", lat, 1);
      bif.req_valid = bif.req_valid & ~oh(exp_ch);
      pend = pend & ~oh(exp_ch);
      rr_ptr = (exp_ch + 1) % NUM_CH;
      if (bif.ch_grant == '0) begin
        bif.req_valid = '0;
        return;
      end
      serve_burst(exp_ch);
    end
  endtask

  initial begin
    bif.req_valid = '0; bif.req_write = '0; bif.req_addr = '0; bif.req_beats = '0;
    bif.ch_wr_data = '0; bif.common_data_bus_in = '0; bif.tx_done = 1'b0; bif.rd_valid = 1'b0;
    repeat (3) step();
    chk_reset("reset");
    rst = 1'b0;
    step();
    chk_reset("idle");

    // All three at once from reset, then ch0+ch2 with the pointer back at 0.
    for (int c = 0; c < NUM_CH; c++) set_req(c, $urandom_range(0, 1), $urandom, $urandom_range(1, 2));
    run_round(3'b111);
    set_req(0, 0, 32'h0000_1000, 1);
    set_req(2, 1, 32'h0000_2000, 2);
    run_round(3'b101);

    set_req(1, 0, 32'h2000_0000, 1);
    t_delay[1] = 10;
    run_round(3'b010);
    set_req(2, 0, 32'h1000_0000, 128);
    run_round(3'b100);
    set_req(2, 1, 32'h0800_0000, 4);
    run_round(3'b100);

    set_req(2, 1, 32'h5000_0000, 0);
    run_round(3'b100);
    set_req(1, 0, 32'hFFFF_FFC0, 2);
    run_round(3'b010);
    set_req(0, 1, 32'hFFFF_FFC0, 3);
    run_round(3'b001);

    set_req(1, 0, 32'h3000_0000, 2);
    t_tmo[1] = 1;
    run_round(3'b010);
    set_req(0, 0, 32'h3000_0040, 2);
    run_round(3'b001);

    for (int r = 0; r < 20; r++) begin
      logic [NUM_CH-1:0] m;
      m = NUM_CH'($urandom_range(1, 7));
      for (int c = 0; c < NUM_CH; c++)
        if (m[c]) set_req(c, $urandom_range(0, 1), $urandom, $urandom_range(0, 5));
      run_round(m);
    end

    // Reset in beat 2 of a 4-beat write on ch0 (pointer had moved to 1).
    rr_ptr = 0;
    set_req(2, 0, 32'h0000_0100, 1);
    run_round(3'b100);
    set_req(0, 1, 32'h4000_0000, 4);
    t_rst[0] = 1;
    run_round(3'b001);
    set_req(0, 0, 32'h6000_0000, 1);
    set_req(1, 0, 32'h7000_0000, 1);
    run_round(3'b011);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
